uart_rx_buffer: RTL and testbench

//   Consumer stage directly downstream of uart_receive. Accepts each received byte via the receiver's

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_rx_buffer_if.sv | 23 ++
 rtl/uart_byte_fifo.sv | 44 ++++
 rtl/uart_rx_buffer.sv | 42 ++++
 tb/tb_uart_rx_buffer.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the receive-side capture FSM encoding
package uart_pkg;
    localparam int DATA_WIDTH = 8;
    typedef enum logic {sIdle = 1'b0, sClear = 1'b1} rx_state_t;
endpackage

// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if: receiver handshake, consumer valid/ack and status signals
interface uart_rx_buffer_if #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_ready;
    logic                  rx_reset_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ack;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  clear_overflow;
    modport master (
        output rx_data, rx_ready, out_ack, clear_overflow,
        input  rx_reset_ready, out_data, out_valid, count, overflow
    );
    modport slave (
        input  rx_data, rx_ready, out_ack, clear_overflow,
        output rx_reset_ready, out_data, out_valid, count, overflow
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word fall-through byte FIFO with an explicit occupancy count
module uart_byte_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop_req,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  valid,
    output logic                  accept
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
    logic [ADDR_WIDTH:0]   next_count;
    logic                  full, pop;
    always_comb begin
        full       = count == (ADDR_WIDTH+1)'(DEPTH);
        pop        = pop_req & valid;
        // a pop frees a slot in the same cycle, so a full FIFO can still accept
        accept     = push & (~full | pop);
        next_count = count + (ADDR_WIDTH+1)'(accept) - (ADDR_WIDTH+1)'(pop);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            valid  <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= next_count;
            valid  <= next_count != '0;
            rd_ptr <= rd_ptr + ADDR_WIDTH'(pop);
            wr_ptr <= wr_ptr + ADDR_WIDTH'(accept);
        end
    end
    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= din;
    assign dout = mem[rd_ptr];
endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: captures bytes from uart_receive into a FIFO and flags drops
module uart_rx_buffer #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input logic              clk,
    input logic              reset,
    uart_rx_buffer_if.slave  bus
);
    import uart_pkg::*;
    rx_state_t state, next_state;
    logic      capture, accept;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= sIdle;
        else       state <= next_state;
    // either state heads to sClear while ready is high and back to sIdle once it drops
    always_comb next_state = bus.rx_ready ? sClear : sIdle;
    always_comb begin
        capture            = (state == sIdle) & bus.rx_ready;
        bus.rx_reset_ready = state == sClear;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset)                  bus.overflow <= 1'b0;
        else if (capture & ~accept) bus.overflow <= 1'b1;
        else if (bus.clear_overflow) bus.overflow <= 1'b0;
    uart_byte_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (capture),
        .pop_req(bus.out_ack),
        .din    (bus.rx_data),
        .dout   (bus.out_data),
        .count  (bus.count),
        .valid  (bus.out_valid),
        .accept (accept)
    );
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed stimulus with an expected-byte queue checked by a pop monitor
module tb_uart_rx_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sb[$];
    uart_rx_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
    uart_rx_buffer #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send_byte(input logic [7:0] b, input int hold, input bit ok);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        if (ok) sb.push_back(b);
        tick();
        check("handshake_ack", 32'(bus.rx_reset_ready), 1);
        repeat (hold - 1) tick();
        bus.rx_ready = 1'b0;
        tick();
        check("handshake_release", 32'(bus.rx_reset_ready), 0);
    endtask
    task automatic pop_n(input int n);
        bus.out_ack = 1'b1;
        repeat (n) tick();
        bus.out_ack = 1'b0;
    endtask
    // scoreboard monitor: every accepted pop must deliver the oldest expected byte
    initial forever begin
        @(negedge clk);
        if (!reset && bus.out_valid && bus.out_ack) begin
            if (sb.size() == 0) check("unexpected_pop", 32'(bus.out_data), 32'hFFFF_FFFF);
            else check("pop_data", 32'(bus.out_data), 32'(sb.pop_front()));
        end
    end
    initial begin
        bus.rx_data = '0;
        bus.rx_ready = 1'b0;
        bus.out_ack = 1'b0;
        bus.clear_overflow = 1'b0;
        repeat (3) tick();
        check("rst_reset_ready", 32'(bus.rx_reset_ready), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        reset = 1'b0;
        tick();
        // single byte with ready held three cycles
        bus.rx_data = 8'hA5;
        bus.rx_ready = 1'b1;
        sb.push_back(8'hA5);
        check("t1_ack_before", 32'(bus.rx_reset_ready), 0);
        tick();
        check("t1_ack", 32'(bus.rx_reset_ready), 1);
        check("t1_valid", 32'(bus.out_valid), 1);
        check("t1_count", 32'(bus.count), 1);
        check("t1_data", 32'(bus.out_data), 32'hA5);
        repeat (2) tick();
        check("t1_count_hold", 32'(bus.count), 1);
        check("t1_ack_hold", 32'(bus.rx_reset_ready), 1);
        bus.rx_ready = 1'b0;
        tick();
        check("t1_ack_drop", 32'(bus.rx_reset_ready), 0);
        pop_n(1);
        check("t1_count_pop", 32'(bus.count), 0);
        check("t1_valid_pop", 32'(bus.out_valid), 0);
        // ordering across pointer wrap
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(i), 2, 1'b1);
            pop_n(1);
        end
        check("t2_overflow", 32'(bus.overflow), 0);
        check("t2_count", 32'(bus.count), 0);
        // fill, overflow, drain, clear
        for (int i = 0; i < 17; i++) send_byte(8'(i), 2, i < 16);
        check("t3_count", 32'(bus.count), 16);
        check("t3_overflow", 32'(bus.overflow), 1);
        pop_n(16);
        check("t3_count_drain", 32'(bus.count), 0);
        check("t3_overflow_kept", 32'(bus.overflow), 1);
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        check("t3_overflow_clr", 32'(bus.overflow), 0);
        // full with a same-cycle pop
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1, 1'b1);
        check("t4_full", 32'(bus.count), 16);
        bus.rx_data = 8'h99;
        bus.rx_ready = 1'b1;
        bus.out_ack = 1'b1;
        sb.push_back(8'h99);
        tick();
        bus.out_ack = 1'b0;
        check("t4_count", 32'(bus.count), 16);
        check("t4_overflow", 32'(bus.overflow), 0);
        bus.rx_ready = 1'b0;
        tick();
        pop_n(16);
        check("t4_drain", 32'(bus.count), 0);
        // long ready period
        send_byte(8'h5A, 10, 1'b1);
        check("t5_count", 32'(bus.count), 1);
        pop_n(1);
        // reset while in sClear with five bytes stored
        for (int i = 0; i < 4; i++) send_byte(8'(8'h60 + i), 1, 1'b1);
        bus.rx_data = 8'h64;
        bus.rx_ready = 1'b1;
        tick();
        check("t6_count_pre", 32'(bus.count), 5);
        check("t6_ack_pre", 32'(bus.rx_reset_ready), 1);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        check("t6_ack_async", 32'(bus.rx_reset_ready), 0);
        check("t6_count", 32'(bus.count), 0);
        check("t6_valid", 32'(bus.out_valid), 0);
        check("t6_overflow", 32'(bus.overflow), 0);
        bus.rx_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        send_byte(8'hC3, 2, 1'b1);
        check("t6_count_after", 32'(bus.count), 1);
        check("t6_data_after", 32'(bus.out_data), 32'hC3);
        pop_n(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
